// File: rtl/sb_pkg.sv
// Shared types for the scoreboard arbiter: scoreboard entry layout, operation codes and FSM states.
package sb_pkg;

  localparam int PROC_COUNT  = 4;
  localparam int KEY_W       = 8;
  localparam int ENTRY_VAL_W = $clog2(PROC_COUNT);

  // key = command id, val = processor id that owns it
  typedef struct packed {
    logic [KEY_W-1:0]       key;
    logic [ENTRY_VAL_W-1:0] val;
  } entry_t;

  typedef enum logic [1:0] {
    SB_READ  = 2'd0,
    SB_WRITE = 2'd1,
    SB_FLUSH = 2'd2
  } sb_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a priority class: prioritised requests win outright, ties rotate from i_ptr.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_prio,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0]     w_cand;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  assign w_cand = (|(i_req & i_prio)) ? (i_req & i_prio) : i_req;
  assign o_any  = |w_cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch behind.
    o_grant = '0;
    o_idx   = '0;
    w_pos   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_pos = IDX_W'((int'(i_ptr) + i) % N);
      if (!w_found && w_cand[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/scoreboard_arbiter.sv
// Serialises READ/WRITE/FLUSH requests onto the single scoreboard port, tracks its occupancy and
// flags a scoreboard that stops answering.
module scoreboard_arbiter
  import sb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DEPTH       = PROC_COUNT,
  parameter  int VAL_W       = ENTRY_VAL_W,
  parameter  int TIMEOUT_CYC = 64,
  localparam int ID_W        = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  sb_op_t [NUM_REQ-1:0]       i_req_op,
  input  entry_t [NUM_REQ-1:0]       i_req_entry,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [ID_W-1:0]            o_rsp_id,
  output logic                       o_rsp_exists,
  output logic [VAL_W-1:0]           o_rsp_val,
  output entry_t                     o_sb_entry,
  output logic                       o_sb_write,
  output logic                       o_sb_read,
  output logic                       o_sb_flush,
  input  logic                       i_sb_ack,
  input  logic                       i_sb_exists,
  input  logic [VAL_W-1:0]           i_sb_val,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_full,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WC_W-1:0]  TO_C    = WC_W'(TIMEOUT_CYC);
  localparam logic [WC_W-1:0]  TO_M1   = WC_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  ID_MAX  = ID_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  sb_op_t             r_op;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_ptr;
  entry_t             r_entry;
  logic               r_sb_write, r_sb_read, r_sb_flush;
  logic [WC_W-1:0]    r_wait_cnt;
  logic               r_err;
  logic [CNT_W-1:0]   r_count;
  logic               r_rsp_valid, r_rsp_exists;
  logic [VAL_W-1:0]   r_rsp_val;

  logic [NUM_REQ-1:0] w_elig, w_prio, w_grant;
  logic [ID_W-1:0]    w_idx;
  logic               w_any, w_full, w_ack, w_tick;

  assign w_full = (r_count == DEPTH_C);
  assign w_ack  = (r_state == ST_WAIT) && i_sb_ack;
  // timeout clock runs from the strobe cycle until the ack arrives
  assign w_tick = (r_state == ST_ISSUE) || ((r_state == ST_WAIT) && !i_sb_ack);

  // a full table masks writes; flushes form the priority class
  always_comb begin
    w_elig = '0;
    w_prio = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = i_req_valid[i] && !((i_req_op[i] == SB_WRITE) && w_full);
      w_prio[i] = (i_req_op[i] == SB_FLUSH);
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req   (w_elig),
    .i_prio  (w_prio),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: all state is assigned with <= so every register samples pre-edge values.
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_op         <= SB_READ;
      r_id         <= '0;
      r_ptr        <= '0;
      r_entry      <= '0;
      r_sb_write   <= 1'b0;
      r_sb_read    <= 1'b0;
      r_sb_flush   <= 1'b0;
      r_wait_cnt   <= '0;
      r_err        <= 1'b0;
      r_count      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_exists <= 1'b0;
      r_rsp_val    <= '0;
    end else begin
      r_sb_write <= 1'b0;
      r_sb_read  <= 1'b0;
      r_sb_flush <= 1'b0;

      if (w_tick) begin
        if (r_wait_cnt != TO_C) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == TO_M1) r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_op    <= i_req_op[w_idx];
            r_id    <= w_idx;
            r_entry <= i_req_entry[w_idx];
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_wait_cnt <= '0;
          r_sb_write <= (r_op == SB_WRITE);
          r_sb_read  <= (r_op == SB_READ);
          r_sb_flush <= (r_op == SB_FLUSH);
          r_state    <= ST_ISSUE;
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (i_sb_ack) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_exists <= (r_op == SB_WRITE) ? 1'b1 : i_sb_exists;
            r_rsp_val    <= ((r_op != SB_WRITE) && i_sb_exists) ? i_sb_val : '0;
            case (r_op)
              SB_WRITE: if (r_count != DEPTH_C) r_count <= r_count + 1'b1;
              SB_FLUSH: if (i_sb_exists && (r_count != '0)) r_count <= r_count - 1'b1;
              default:  ;
            endcase
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_id == ID_MAX) ? '0 : r_id + 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready  = ((r_state == ST_IDLE) && !i_rst) ? w_grant : '0;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_id;
  assign o_rsp_exists = r_rsp_exists;
  assign o_rsp_val    = r_rsp_val;
  assign o_sb_entry   = r_entry;
  assign o_sb_write   = r_sb_write;
  assign o_sb_read    = r_sb_read;
  assign o_sb_flush   = r_sb_flush;
  assign o_count      = r_count;
  assign o_full       = w_full;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_err        = r_err;

  a_ack_in_wait: assert property (@(posedge i_clk) disable iff (i_rst)
    i_sb_ack |-> (r_state == ST_WAIT));
  a_one_strobe: assert property (@(posedge i_clk)
    $onehot0({r_sb_write, r_sb_read, r_sb_flush}));
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    (w_ack && (r_op == SB_WRITE)) |-> (r_count != DEPTH_C));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    (w_ack && (r_op == SB_FLUSH) && i_sb_exists) |-> (r_count != '0));

endmodule

// File: tb/tb_scoreboard_arbiter.sv
// Directed bench for scoreboard_arbiter against a small behavioural scoreboard with a mute switch.
module tb_scoreboard_arbiter;
  import sb_pkg::*;

  localparam int NR    = 4;
  localparam int DEPTH = PROC_COUNT;
  localparam int TO    = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid, req_ready;
  sb_op_t [NR-1:0]   req_op;
  entry_t [NR-1:0]   req_entry;
  logic              rsp_valid, rsp_ready, rsp_exists;
  logic [1:0]        rsp_id, rsp_val;
  entry_t            sb_entry;
  logic              sb_write, sb_read, sb_flush;
  logic              sb_ack = 1'b0, sb_exists = 1'b0;
  logic [1:0]        sb_val = '0;
  logic [2:0]        count;
  logic              full, busy, err;

  scoreboard_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_entry(req_entry),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_id(rsp_id), .o_rsp_exists(rsp_exists), .o_rsp_val(rsp_val),
    .o_sb_entry(sb_entry), .o_sb_write(sb_write), .o_sb_read(sb_read), .o_sb_flush(sb_flush),
    .i_sb_ack(sb_ack), .i_sb_exists(sb_exists), .i_sb_val(sb_val),
    .o_count(count), .o_full(full), .o_busy(busy), .o_err(err)
  );

  // behavioural scoreboard: answers one cycle after a strobe, never completes a write when full
  entry_t sb_tab [DEPTH];
  logic   sb_v   [DEPTH];
  bit     stub_mute = 1'b0;

  function automatic int find_key(input logic [7:0] k);
    for (int i = 0; i < DEPTH; i++) if (sb_v[i] && sb_tab[i].key == k) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < DEPTH; i++) if (!sb_v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    sb_ack <= 1'b0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb_v[i] <= 1'b0;
      sb_exists <= 1'b0;
      sb_val    <= '0;
    end else if (!stub_mute) begin
      if (sb_write) begin
        if (find_free() >= 0) begin
          sb_tab[find_free()] <= sb_entry;
          sb_v[find_free()]   <= 1'b1;
          sb_ack    <= 1'b1;
          sb_exists <= 1'b1;
          sb_val    <= '0;
        end
      end else if (sb_read || sb_flush) begin
        sb_ack    <= 1'b1;
        sb_exists <= (find_key(sb_entry.key) >= 0);
        sb_val    <= (find_key(sb_entry.key) >= 0) ? sb_tab[find_key(sb_entry.key)].val : 2'd0;
        if (sb_flush && find_key(sb_entry.key) >= 0) sb_v[find_key(sb_entry.key)] <= 1'b0;
      end
    end
  end

  // cycle monitor: during cycle n, cyc == n
  int     cyc = 0, grant_cyc = 0, strobe_cyc = 0, strobe_total = 0, multi_strobe = 0;
  sb_op_t strobe_op = SB_READ;
  always @(posedge clk) begin
    if (|(req_ready & req_valid)) grant_cyc <= cyc;
    if (sb_write || sb_read || sb_flush) begin
      strobe_cyc   <= cyc;
      strobe_total <= strobe_total + 1;
      strobe_op    <= sb_write ? SB_WRITE : (sb_read ? SB_READ : SB_FLUSH);
    end
    if ((int'(sb_write) + int'(sb_read) + int'(sb_flush)) > 1) multi_strobe <= multi_strobe + 1;
    cyc <= cyc + 1;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_grant(output logic [NR-1:0] g);
    g = '0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (|req_ready) begin
        g = req_ready;
        return;
      end
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL grant_timeout: no grant within 100 cycles (cycle %0d)", cyc);
  endtask

  task automatic wait_rsp(output logic [1:0] id, output logic ex, output logic [1:0] val,
                          output int at);
    id = '0; ex = 1'b0; val = '0; at = cyc;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rsp_valid) begin
        id = rsp_id; ex = rsp_exists; val = rsp_val; at = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL rsp_timeout: no response within 100 cycles (cycle %0d)", cyc);
  endtask

  typedef struct {
    logic [1:0] req;
    sb_op_t     op;
    logic [7:0] key;
    logic [1:0] val;
    logic       exp_ex;
    logic [1:0] exp_val;
    logic [2:0] exp_cnt;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [NR-1:0] g;
    logic [1:0]    id, val;
    logic          ex;
    int            s0, at;
    s0 = strobe_total;
    req_op[v.req]    = v.op;
    req_entry[v.req] = '{key: v.key, val: v.val};
    req_valid[v.req] = 1'b1;
    wait_grant(g);
    check("vec_grant", 32'(g), 32'(4'b0001 << v.req));
    @(negedge clk);
    req_valid[v.req] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("vec_id", 32'(id), 32'(v.req));
    check("vec_exists", 32'(ex), 32'(v.exp_ex));
    check("vec_val", 32'(val), 32'(v.exp_val));
    check("vec_count", 32'(count), 32'(v.exp_cnt));
    check("vec_grant_to_strobe", 32'(strobe_cyc - grant_cyc), 32'd2);
    check("vec_strobe_op", 32'(strobe_op), 32'(v.op));
    check("vec_strobe_once", 32'(strobe_total - s0), 32'd1);
    check("vec_strobe_to_rsp", 32'(at - strobe_cyc), 32'd2);
  endtask

  vec_t vecs [12];

  initial begin
    logic [NR-1:0] g;
    logic [1:0]    id, val;
    logic          ex;
    int            at, gc, s0;
    bit            seen;

    vecs[0]  = '{2'd0, SB_WRITE, 8'd5,  2'd2, 1'b1, 2'd0, 3'd1};
    vecs[1]  = '{2'd1, SB_READ,  8'd5,  2'd0, 1'b1, 2'd2, 3'd1};
    vecs[2]  = '{2'd1, SB_READ,  8'd9,  2'd0, 1'b0, 2'd0, 3'd1};
    vecs[3]  = '{2'd3, SB_WRITE, 8'd9,  2'd1, 1'b1, 2'd0, 3'd2};
    vecs[4]  = '{2'd2, SB_FLUSH, 8'd9,  2'd0, 1'b1, 2'd1, 3'd1};
    vecs[5]  = '{2'd2, SB_FLUSH, 8'd9,  2'd0, 1'b0, 2'd0, 3'd1};
    vecs[6]  = '{2'd0, SB_READ,  8'd9,  2'd0, 1'b0, 2'd0, 3'd1};
    vecs[7]  = '{2'd1, SB_WRITE, 8'd7,  2'd3, 1'b1, 2'd0, 3'd2};
    vecs[8]  = '{2'd0, SB_FLUSH, 8'd7,  2'd0, 1'b1, 2'd3, 3'd1};
    vecs[9]  = '{2'd0, SB_WRITE, 8'd10, 2'd0, 1'b1, 2'd0, 3'd2};
    vecs[10] = '{2'd1, SB_WRITE, 8'd11, 2'd1, 1'b1, 2'd0, 3'd3};
    vecs[11] = '{2'd3, SB_WRITE, 8'd12, 2'd3, 1'b1, 2'd0, 3'd4};

    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    req_op = {NR{SB_READ}}; req_entry = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", 32'({count, busy, err, rsp_valid, sb_write, sb_read, sb_flush, req_ready}), 32'd0);
    check("rst_entry", 32'(sb_entry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);
    check("full_after_fill", 32'(full), 32'd1);

    // full table: flush wins, then the freed slot lets the write in on the next IDLE cycle
    req_op[0] = SB_WRITE; req_entry[0] = '{key: 8'd20, val: 2'd0}; req_valid[0] = 1'b1;
    req_op[2] = SB_FLUSH; req_entry[2] = '{key: 8'd5,  val: 2'd0}; req_valid[2] = 1'b1;
    wait_grant(g);
    check("full_flush_first", 32'(g), 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("full_flush_rsp", 32'({id, ex, val}), 32'({2'd2, 1'b1, 2'd2}));
    check("full_flush_count", 32'(count), 32'd3);
    wait_grant(g);
    gc = cyc;
    check("full_write_next", 32'(g), 32'b0001);
    check("full_write_unmask_cyc", 32'(gc - at), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("full_write_rsp", 32'({id, ex}), 32'({2'd0, 1'b1}));
    check("full_write_count", 32'(count), 32'd4);

    // still full: a write stays masked while a read is served
    req_op[1] = SB_WRITE; req_entry[1] = '{key: 8'd30, val: 2'd1}; req_valid[1] = 1'b1;
    req_op[3] = SB_READ;  req_entry[3] = '{key: 8'd10, val: 2'd0}; req_valid[3] = 1'b1;
    wait_grant(g);
    check("full_read_served", 32'(g), 32'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("full_read_rsp", 32'({id, ex, val}), 32'({2'd3, 1'b1, 2'd0}));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("full_write_masked", 32'({req_ready, busy}), 32'd0);
    end
    req_valid[1] = 1'b0;

    // all requesters read continuously: strict rotation
    for (int r = 0; r < NR; r++) begin
      req_op[r] = SB_READ; req_entry[r] = '{key: 8'd11, val: 2'd0};
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      wait_grant(g);
      check("rr_grant", 32'(g), 32'(4'b0001 << (k % NR)));
      wait_rsp(id, ex, val, at);
      check("rr_rsp", 32'({id, ex, val}), 32'({2'(k % NR), 1'b1, 2'd1}));
      if (k == 7) req_valid = '0;
    end

    // backpressure on the response: everything holds for 10 cycles
    req_op[2] = SB_READ; req_entry[2] = '{key: 8'd12, val: 2'd0}; req_valid[2] = 1'b1;
    wait_grant(g);
    check("hold_grant", 32'(g), 32'b0100);
    @(negedge clk);
    req_valid[2] = 1'b0;
    req_op[0] = SB_READ; req_entry[0] = '{key: 8'd10, val: 2'd0}; req_valid[0] = 1'b1;
    rsp_ready = 1'b0;
    wait_rsp(id, ex, val, at);
    s0 = strobe_total;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("hold_stable",
            32'({rsp_valid, rsp_id, rsp_exists, rsp_val, req_ready, sb_write, sb_read, sb_flush, busy}),
            32'({1'b1, 2'd2, 1'b1, 2'd3, 4'b0000, 3'b000, 1'b1}));
    end
    check("hold_no_strobe", 32'(strobe_total - s0), 32'd0);
    rsp_ready = 1'b1;
    wait_grant(g);
    check("hold_next_grant", 32'(g), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("hold_next_rsp", 32'({id, ex, val}), 32'({2'd0, 1'b1, 2'd0}));

    // silent scoreboard: o_err rises TO cycles after the strobe, reset clears everything
    stub_mute = 1'b1;
    req_op[1] = SB_READ; req_entry[1] = '{key: 8'd10, val: 2'd0}; req_valid[1] = 1'b1;
    wait_grant(g);
    check("to_grant", 32'(g), 32'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk); #1;
      if (err) seen = 1'b1;
    end
    check("to_err_seen", 32'(seen), 32'd1);
    check("to_err_delay", 32'(cyc - strobe_cyc), 32'(TO));
    check("to_state", 32'({busy, rsp_valid}), 32'({1'b1, 1'b0}));
    repeat (3) @(negedge clk);
    check("to_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("to_reset_clear", 32'({err, busy, count, rsp_valid, req_ready}), 32'd0);
    rst = 1'b0;
    stub_mute = 1'b0;
    @(negedge clk);

    // flush outranks an earlier-in-rotation read
    req_op[0] = SB_READ;  req_entry[0] = '{key: 8'd1, val: 2'd0}; req_valid[0] = 1'b1;
    req_op[1] = SB_FLUSH; req_entry[1] = '{key: 8'd1, val: 2'd0}; req_valid[1] = 1'b1;
    wait_grant(g);
    check("prio_flush", 32'(g), 32'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("prio_flush_rsp", 32'({id, ex, val}), 32'({2'd1, 1'b0, 2'd0}));
    wait_grant(g);
    check("prio_read_next", 32'(g), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(id, ex, val, at);
    check("prio_read_rsp", 32'({id, ex}), 32'({2'd0, 1'b0}));

    run_vec('{2'd2, SB_WRITE, 8'd40, 2'd2, 1'b1, 2'd0, 3'd1});

    check("no_multi_strobe", 32'(multi_strobe), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
